periph_rr_arbiter: RTL and testbench
====================================

Name: periph_rr_arbiter

Overview:
- Four-requester round-robin arbiter for the Peripheral Unit's shared peripheral port.
- Grants one requester at a time and drives the 2-bit select of the downstream 4:1 data mux.
- Holds the grant until the peripheral acknowledges, the requester withdraws, or a watchdog timeout fires.
- Sits between the bus masters (CPU, DMA, debug, spare) and the shared peripheral datapath.

Parameters:
- TIMEOUT, 15, max cycles a grant may wait for ack before abort; legal range 1..255.
- CNT_W, 8, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request lines; bit i is requester i; level-sensitive.
- ack  input  1  one-cycle completion pulse from the shared peripheral.
- sel  output  2  mux select = index of current/last granted requester.
- gnt  output  4  one-hot grant; all-zero when idle.
- busy  output  1  high while a grant is active.
- timeout_err  output  1  one-cycle pulse when a grant is aborted by the watchdog.

Behaviour:
- Reset (async, active-high): state=IDLE, sel=0, gnt=0, busy=0, timeout_err=0, watchdog=0, last pointer=3, so requester 0 has first priority.
- All outputs are registered; no combinational path from req/ack to any output.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, pick the first set bit scanning (last+1) mod 4 upward with wrap.
  - Next edge: sel=winner, gnt=onehot(winner), busy=1, watchdog=0, state=GRANT.
  - Latency from req to gnt is 1 cycle.
  - If req==0, remain in IDLE; sel holds its previous value.
- GRANT, exit priority ack > withdraw > timeout; all exits go to IDLE on the next edge with gnt=0, busy=0:
  - ack=1: last=sel.
  - req[sel]=0 (withdraw): last=sel.
  - watchdog==TIMEOUT-1 with no ack: last=sel, timeout_err=1 for exactly that cycle.
  - Otherwise watchdog+=1 per cycle; it saturates, never wraps.
- ack while in IDLE is ignored; no error flag.
- Changes to other requesters' req bits during GRANT are ignored until return to IDLE.
- IDLE always lasts at least one cycle between grants (bus turnaround). Minimum grant-to-grant spacing is 2 cycles after ack.
- Single persistent requester: re-granted every second cycle after each ack; no starvation.
- Fairness: with all four requesting continuously, grant order is 0,1,2,3,0,…; the pointer updates on every grant exit, including timeout.
- Reset mid-GRANT: immediate return to reset values; no timeout_err pulse.
- gnt is always zero or one-hot, and gnt!=0 iff busy.

Decomposition:
- Package periph_arb_pkg holds:
  - NUM_REQ=4, SEL_W=2.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
  - Function onehot4(sel) returning logic [3:0].
- One sub-module, rr_pick: combinational rotate-priority-encode of (req, last) -> (valid, winner[1:0]). It is unit-testable on its own.
- The 4:1 data mux is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then req=4'b0001 and ack pulsed 3 cycles after gnt -> gnt=0001, sel=0 one cycle after req; gnt=0000, busy=0 the cycle after ack.
- req=4'b1111 held, ack one cycle after each grant -> grant sequence sel=0,1,2,3,0, each separated by one IDLE cycle.
- last=1, req=4'b0011 -> sel=0 (wrap from 3 to 0); next grant sel=1.
- req=4'b0100, no ack, TIMEOUT=15 -> timeout_err high exactly 15 cycles after gnt, gnt drops the same edge, next req=0100 re-granted after one IDLE cycle.
- Grant to requester 2, deassert req[2] before ack -> gnt=0000 next edge, no timeout_err; a late ack in IDLE has no effect.
- Assert reset asynchronously mid-GRANT (between edges) -> gnt, busy, sel go to 0 immediately; after release, req=1000 is granted sel=3 on the following edge (pointer back to 3, priority 0 first but only 3 requests).

Source files
------------

// File: rtl/periph_arb_pkg.sv
// Shared types and constants for the four-requester peripheral port arbiter.
package periph_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/periph_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request scanning upward from last+1, wrapping.
module rr_pick
  import periph_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               valid,
  output logic [SEL_W-1:0]   winner
);

  always_comb begin
    logic [SEL_W-1:0] idx;
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    // idx wraps naturally in SEL_W bits; i == NUM_REQ lands back on last itself
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last + SEL_W'(i);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/periph_rr_arbiter.sv
// Round-robin arbiter for the shared peripheral port: grant held until ack,
// withdraw or watchdog timeout, with one IDLE turnaround cycle between grants.
module periph_rr_arbiter
  import periph_arb_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ack,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               timeout_err
);

  arb_state_t         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               terr_q, terr_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;

  logic               pick_valid;
  logic [SEL_W-1:0]   pick_winner;

  rr_pick u_pick (
    .req    (req),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    terr_d  = 1'b0;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          sel_d   = pick_winner;
          gnt_d   = onehot4(pick_winner);
          busy_d  = 1'b1;
          wdog_d  = '0;
        end
      end
      GRANT: begin
        if (ack || !req[sel_q] || (wdog_q == CNT_W'(TIMEOUT - 1))) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          last_d  = sel_q;
          terr_d  = !ack && req[sel_q];
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      wdog_q  <= wdog_d;
    end
  end

  assign sel         = sel_q;
  assign gnt         = gnt_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_periph_rr_arbiter.sv
// Scoreboard bench for periph_rr_arbiter: directed scenarios plus random traffic
// checked against a cycle-level reference model of the round-robin rules.
module tb_periph_rr_arbiter;

  localparam int TIMEOUT = 15;

  logic       clk, reset;
  logic [3:0] req;
  logic       ack;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy, timeout_err;

  periph_rr_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .ack         (ack),
    .sel         (sel),
    .gnt         (gnt),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp, mon_got;
  int n_cmp = 0;
  int n_bad = 0;

  // reference model: owner index, last-served index, edge of the grant
  int m_last = 3, m_sel = 0, m_gstart = 0, m_edge = 0;
  bit m_busy = 1'b0, m_terr = 1'b0;

  function automatic logic [7:0] pack_exp();
    logic [3:0] g;
    g = m_busy ? (4'b0001 << m_sel) : 4'b0000;
    return {2'(m_sel), g, m_busy, m_terr};
  endfunction

  task automatic model_step(input logic rst, input logic [3:0] r, input logic a);
    bit found;
    m_edge++;
    if (rst) begin
      m_busy = 1'b0; m_sel = 0; m_last = 3; m_terr = 1'b0;
      return;
    end
    m_terr = 1'b0;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && r[(m_last + k) % 4]) begin
          found    = 1'b1;
          m_sel    = (m_last + k) % 4;
          m_busy   = 1'b1;
          m_gstart = m_edge;
        end
      end
    end else if (a || !r[m_sel]) begin
      m_busy = 1'b0;
      m_last = m_sel;
    end else if (m_edge - m_gstart == TIMEOUT) begin
      m_busy = 1'b0;
      m_last = m_sel;
      m_terr = 1'b1;
    end
  endtask

  task automatic cycle(input logic rst, input logic [3:0] r, input logic a);
    @(negedge clk);
    reset = rst;
    req   = r;
    ack   = a;
    model_step(rst, r, a);
    exp_q.push_back(pack_exp());
    @(posedge clk);
  endtask

  task automatic async_reset_mid_grant();
    @(negedge clk);
    ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({sel, gnt, busy} !== 7'b0) begin
      n_bad++;
      $display("FAIL async_reset: got sel=%0d gnt=%b busy=%b, expected sel=0 gnt=0000 busy=0",
               sel, gnt, busy);
    end
    model_step(1'b1, req, 1'b0);
    exp_q.push_back(pack_exp());
    @(posedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_got = {sel, gnt, busy, timeout_err};
        n_cmp++;
        if (mon_got !== mon_exp) begin
          n_bad++;
          $display("FAIL outputs t=%0t: got sel=%0d gnt=%b busy=%b terr=%b, expected sel=%0d gnt=%b busy=%b terr=%b",
                   $time, mon_got[7:6], mon_got[5:2], mon_got[1], mon_got[0],
                   mon_exp[7:6], mon_exp[5:2], mon_exp[1], mon_exp[0]);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic       a;
    reset = 1'b1;
    req   = 4'b0;
    ack   = 1'b0;

    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0);

    // single requester, ack three cycles after grant
    cycle(1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0001, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);

    // all four requesting, ack right after each grant
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b1111, 1'b0);
      cycle(1'b0, 4'b1111, 1'b1);
    end
    cycle(1'b0, 4'b0000, 1'b0);

    // last=1 then 0011: wrap to 0, then 1
    cycle(1'b0, 4'b0010, 1'b0);
    cycle(1'b0, 4'b0010, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 4'b0011, 1'b0);
      cycle(1'b0, 4'b0011, 1'b1);
    end
    cycle(1'b0, 4'b0000, 1'b0);

    // watchdog abort and regrant
    for (int i = 0; i < 20; i++) cycle(1'b0, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0100, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0);

    // withdraw, then a late ack while idle
    cycle(1'b0, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0);

    // async reset in the middle of a grant
    cycle(1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0001, 1'b0);
    async_reset_mid_grant();
    cycle(1'b0, 4'b1000, 1'b0);
    cycle(1'b0, 4'b1000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0);

    // random traffic: slowly changing requests, sparse acks
    r = 4'b0;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(15) == 0) r[b] = ~r[b];
      a = ($urandom_range(7) == 0);
      cycle(1'b0, r, a);
    end

    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
